// File: rtl/secure_serdes_pkg.sv
// Shared definitions for the secure serdes encryptor/decryptor pair.
package secure_serdes_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/secure_serdes_decryptor_sipo.sv
// Serial-in parallel-out shift register, MSB first.
module sipo_shift_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              din,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (en) sr_d = {sr_q[DATA_W-2:0], din};
   end

   always_ff @(posedge clk) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign q = sr_q;

endmodule

// File: rtl/secure_serdes_decryptor.sv
// Deserialises a cipher frame and its key frame, delivers cipher XOR key
// on a valid/ack port and counts delivered frames.
module secure_serdes_decryptor
   import secure_serdes_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              c_bit,
   input  logic              k_bit,
   output logic [DATA_W-1:0] plain,
   output logic              valid,
   input  logic              ack,
   output logic              busy,
   output logic              overrun,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int BC_W = clog2(DATA_W);
   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_SHIFT = SHIFT;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

   // Handshake: plain is offered while valid=1 and is taken on any edge where
   // ack=1; a frame completing on that same edge replaces it and keeps valid=1.

   logic [0:0]        state_q, state_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] plain_q, plain_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DATA_W-1:0] c_sr, k_sr;
   logic              shift_en;

   assign shift_en = (state_q == ST_SHIFT);

   sipo_shift_reg #(.DATA_W(DATA_W)) u_cipher_sr (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .din (c_bit),
      .q   (c_sr)
   );

   sipo_shift_reg #(.DATA_W(DATA_W)) u_key_sr (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .din (k_bit),
      .q   (k_sr)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      plain_d   = plain_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      overrun_d = overrun_q;
      cnt_d     = cnt_q;

      if (valid_q && ack) valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
            end
         end
         ST_SHIFT: begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
               // The final bit is taken straight from the line, not the register.
               plain_d   = {c_sr[DATA_W-2:0], c_bit} ^ {k_sr[DATA_W-2:0], k_bit};
               valid_d   = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               state_d   = ST_IDLE;
               busy_d    = 1'b0;
               bit_cnt_d = '0;
               if (valid_q && !ack) overrun_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         plain_q   <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         plain_q   <= plain_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         cnt_q     <= cnt_d;
      end
   end

   assign plain     = plain_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_secure_serdes_decryptor.sv
// Directed bench for secure_serdes_decryptor (DATA_W=8, CNT_W=2).
module tb_secure_serdes_decryptor;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;

   logic              clk;
   logic              rst;
   logic              start;
   logic              c_bit;
   logic              k_bit;
   logic [DATA_W-1:0] plain;
   logic              valid;
   logic              ack;
   logic              busy;
   logic              overrun;
   logic [CNT_W-1:0]  frame_cnt;

   int checks;
   int errors;

   secure_serdes_decryptor #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .c_bit     (c_bit),
      .k_bit     (k_bit),
      .plain     (plain),
      .valid     (valid),
      .ack       (ack),
      .busy      (busy),
      .overrun   (overrun),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_plain", 32'(plain), 32'h0);
      check_eq("rst_valid", 32'(valid), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_overrun", 32'(overrun), 32'h0);
      check_eq("rst_cnt", 32'(frame_cnt), 32'h0);
   endtask

   // Start cycle, then DATA_W bit cycles; returns #1 after the last-bit edge.
   task automatic send_frame(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] k,
                             input int restart_at, input logic ack_last);
      start = 1'b1;
      c_bit = 1'b1;
      k_bit = 1'b0;
      tick();
      for (int i = 0; i < DATA_W; i++) begin
         c_bit = c[DATA_W-1-i];
         k_bit = k[DATA_W-1-i];
         start = (i == restart_at);
         ack   = ack_last && (i == DATA_W - 1);
         check_eq("busy_shift", 32'(busy), 32'h1);
         tick();
      end
      start = 1'b0;
      ack   = 1'b0;
      c_bit = 1'b0;
      k_bit = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      start = 1'b0;
      c_bit = 1'b0;
      k_bit = 1'b0;
      ack = 1'b0;
      #2;

      // Basic frame and latency
      do_reset();
      send_frame(8'h01, 8'h03, -1, 1'b0);
      check_eq("t1_plain", 32'(plain), 32'h02);
      check_eq("t1_valid", 32'(valid), 32'h1);
      check_eq("t1_busy", 32'(busy), 32'h0);
      check_eq("t1_cnt", 32'(frame_cnt), 32'h1);
      check_eq("t1_overrun", 32'(overrun), 32'h0);

      // Round trip: cipher 0xC3^0x5A = 0x99, then ack
      do_reset();
      send_frame(8'h99, 8'h5A, -1, 1'b0);
      check_eq("t2_plain", 32'(plain), 32'hC3);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("t2_valid_ack", 32'(valid), 32'h0);
      check_eq("t2_plain_hold", 32'(plain), 32'hC3);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("t2_ack_idle", 32'(valid), 32'h0);
      check_eq("t2_ack_idle_plain", 32'(plain), 32'hC3);

      // Back-to-back frames with no ack
      do_reset();
      send_frame(8'hFF, 8'h0F, -1, 1'b0);
      check_eq("t3_plain1", 32'(plain), 32'hF0);
      check_eq("t3_overrun1", 32'(overrun), 32'h0);
      send_frame(8'h00, 8'hAA, -1, 1'b0);
      check_eq("t3_plain2", 32'(plain), 32'hAA);
      check_eq("t3_valid2", 32'(valid), 32'h1);
      check_eq("t3_overrun2", 32'(overrun), 32'h1);
      check_eq("t3_cnt", 32'(frame_cnt), 32'h2);

      // Start pulse mid-frame is ignored
      do_reset();
      send_frame(8'hA5, 8'h00, 2, 1'b0);
      check_eq("t4_plain", 32'(plain), 32'hA5);
      check_eq("t4_cnt", 32'(frame_cnt), 32'h1);
      for (int i = 0; i < 12; i++) tick();
      check_eq("t4_busy_after", 32'(busy), 32'h0);
      check_eq("t4_cnt_after", 32'(frame_cnt), 32'h1);

      // Reset mid-frame aborts it
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         c_bit = 1'b1;
         k_bit = 1'b0;
         tick();
      end
      do_reset();
      for (int i = 0; i < 12; i++) tick();
      check_eq("t5_no_output", 32'(valid), 32'h0);
      send_frame(8'h3C, 8'hFF, -1, 1'b0);
      check_eq("t5_plain", 32'(plain), 32'hC3);
      check_eq("t5_cnt", 32'(frame_cnt), 32'h1);

      // ack coinciding with completion, then counter wrap
      do_reset();
      send_frame(8'h12, 8'h00, -1, 1'b0);
      check_eq("t6_plain1", 32'(plain), 32'h12);
      send_frame(8'h34, 8'h00, -1, 1'b1);
      check_eq("t6_plain2", 32'(plain), 32'h34);
      check_eq("t6_valid2", 32'(valid), 32'h1);
      check_eq("t6_overrun2", 32'(overrun), 32'h0);
      for (int f = 0; f < 3; f++) begin
         ack = 1'b1;
         tick();
         ack = 1'b0;
         send_frame(8'h55, 8'h0F, -1, 1'b0);
      end
      check_eq("t6_plain5", 32'(plain), 32'h5A);
      check_eq("t6_cnt_wrap", 32'(frame_cnt), 32'h1);
      check_eq("t6_overrun5", 32'(overrun), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/secure_serdes_decryptor.md
Name: secure_serdes_decryptor

Overview:
Receive-side counterpart of the secure serdes encryptor. Deserialises one MSB-first cipher frame and the matching key frame, clocked in bit-parallel on two serial lines after a start pulse. Recovers plaintext as cipher XOR key and presents it on a parallel valid/ack output port. Sits between the serial link pins and the consumer logic, and counts delivered frames.

Parameters:
DATA_W, 8, frame width in bits (cipher, key and plaintext); legal range 2..32
CNT_W, 8, width of the delivered-frame counter

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  frame-start strobe, one cycle wide; sampled in IDLE only
c_bit  in  1  serial cipher bit, MSB first
k_bit  in  1  serial key bit, MSB first, aligned with c_bit
plain  out  DATA_W  recovered plaintext; holds until the next frame completes
valid  out  1  plain holds an unacknowledged frame
ack  in  1  consumer accepts plain; effective only while valid=1
busy  out  1  a frame is being shifted in
overrun  out  1  sticky flag: a completed frame overwrote an unacked one
frame_cnt  out  CNT_W  number of frames delivered; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; plain=0; valid=0; busy=0; overrun=0; frame_cnt=0; shift registers and bit counter cleared. Reset mid-frame discards the partial frame. No output is produced for that frame.
- States: IDLE, SHIFT.
- IDLE: start=1 at an edge -> SHIFT, bit_cnt=0, busy=1 from the next cycle. c_bit/k_bit in the start cycle are ignored.
- SHIFT: each edge shifts c_sr <= {c_sr[DATA_W-2:0], c_bit} and k_sr the same way with k_bit, then bit_cnt++. The first data bit is the one present in the cycle after start.
- On the edge sampling bit DATA_W-1 (the last bit):
  - plain <= {c_sr[DATA_W-2:0],c_bit} XOR {k_sr[DATA_W-2:0],k_bit}
  - valid <= 1; frame_cnt++; state -> IDLE; busy <= 0
- Latency: plain and valid are visible one cycle after the last bit cycle, i.e. DATA_W+1 cycles after the start cycle.
- start while in SHIFT: ignored, no restart. A new frame may start in the first IDLE cycle after completion, giving back-to-back frames every DATA_W+1 cycles.
- ack=1 with valid=1 at an edge: valid <= 0; plain holds its value. ack with valid=0: no effect.
- Completion while valid=1 and ack=0: plain overwritten with the new frame, valid stays 1, overrun <= 1.
- Completion and ack=1 in the same cycle: new frame wins; valid stays 1; overrun unchanged.
- overrun clears only on rst.
- frame_cnt wraps from 2^CNT_W-1 to 0 without any flag.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package secure_serdes_pkg holds:
  - DATA_W default constant, shared with the encryptor
  - state enum {IDLE, SHIFT}
  - bit-counter width function clog2(DATA_W)
- One natural sub-module, sipo_shift_reg (parameter DATA_W; clk, rst, en, din, q). It is instantiated twice, once for cipher and once for key. The FSM, XOR, handshake and counter stay in the top.

Test Plan:
- Reset, start, then cipher 0x01 with key 0x03, MSB first -> plain=0x02 and valid=1 exactly 9 cycles after the start cycle; busy=1 for cycles 1..8; frame_cnt=1; overrun=0.
- Round trip: encryptor output for A=0xC3, B=0x5A fed to this block with key 0x5A -> plain=0xC3. Then ack=1 for one cycle -> valid=0 next cycle, plain still 0xC3.
- Two back-to-back frames (0xFF^0x0F, then 0x00^0xAA) with no ack -> plain=0xF0 then 0xAA; overrun=1 after the second completion; frame_cnt=2.
- start pulsed again 3 cycles into a frame (cipher 0xA5, key 0x00) -> pulse ignored; plain=0xA5 at the normal cycle; no extra frame; frame_cnt=1.
- rst asserted after 4 bits of a frame, then a fresh frame with cipher 0x3C and key 0xFF -> no output from the aborted frame; plain=0xC3; frame_cnt=1.
- ack held high across a completion edge while valid=1 -> new plain loaded, valid stays 1, overrun stays 0. With CNT_W=2 and 5 frames delivered -> frame_cnt wraps to 1.
